// File: rtl/des_pkg.sv
// Shared DES sequencing definitions: FSM states, round count, key bank codes and
// the per-pass direction/key table used when TDES_EN is defined.
package des_pkg;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_ROUND = 2'd1,
        ST_DONE  = 2'd2
    } state_e;

    localparam logic [4:0] ROUNDS = 5'd16;

    localparam logic [1:0] KEY_K1 = 2'd1;
    localparam logic [1:0] KEY_K2 = 2'd2;
    localparam logic [1:0] KEY_K3 = 2'd3;

    // Triple-DES runs E-D-E for encrypt and D-E-D for decrypt; the middle pass flips.
    function automatic logic pass_is_decrypt(input logic dec, input logic [1:0] pass);
        logic res;
        case (pass)
            2'd0:    res = dec;
            2'd1:    res = ~dec;
            2'd2:    res = dec;
            default: res = dec;
        endcase
        return res;
    endfunction

    // Encrypt walks K1,K2,K3; decrypt walks K3,K2,K1.
    function automatic logic [1:0] pass_key(input logic dec, input logic [1:0] pass);
        logic [1:0] res;
        case (pass)
            2'd0:    res = dec ? KEY_K3 : KEY_K1;
            2'd1:    res = KEY_K2;
            2'd2:    res = dec ? KEY_K1 : KEY_K3;
            default: res = KEY_K1;
        endcase
        return res;
    endfunction

endpackage

// File: rtl/des_round_sequencer_swap.sv
// Final half exchange of a DES pass: (L16, R16) becomes (R16, L16).
module des_round_sequencer_swap (
    input  logic [32:1] l_in,
    input  logic [32:1] r_in,
    output logic [32:1] l_out,
    output logic [32:1] r_out
);

    assign l_out = r_in;
    assign r_out = l_in;

endmodule

// File: rtl/des_round_sequencer.sv
// DES round sequencer: steps the Feistel network one round per cycle against an
// external f-function and key schedule. Define TDES_EN for three-pass Triple-DES.
module des_round_sequencer
    import des_pkg::*;
(
    input  logic        clk,
    input  logic        reset_n,
    input  logic        in_valid,
    output logic        in_ready,
    input  logic        decrypt,
    input  logic [32:1] left0,
    input  logic [32:1] right0,
    output logic [32:1] f_right,
    input  logic [32:1] f_out,
    output logic [4:1]  round_num,
    output logic [2:1]  key_sel,
    output logic        out_valid,
    input  logic        out_ready,
    output logic [32:1] left_out,
    output logic [32:1] right_out
);

    state_e      state_r;
    state_e      state_nxt_s;
    logic [32:1] l_r;
    logic [32:1] r_r;
    logic [4:0]  rnd_r;
    logic [1:0]  pass_r;
    logic        dec_r;
    logic [32:1] left_out_r;
    logic [32:1] right_out_r;
    logic [32:1] l_next_s;
    logic [32:1] r_next_s;
    logic [32:1] swap_l_s;
    logic [32:1] swap_r_s;
    logic        last_round_s;
    logic        last_pass_s;
    logic        pass_dec_s;

`ifdef TDES_EN
    localparam logic [1:0] LAST_PASS = 2'd2;
    assign pass_dec_s = pass_is_decrypt(dec_r, pass_r);
    assign key_sel    = pass_key(dec_r, pass_r);
`else
    localparam logic [1:0] LAST_PASS = 2'd0;
    assign pass_dec_s = dec_r;
    assign key_sel    = KEY_K1;
`endif

    assign l_next_s     = r_r;
    assign r_next_s     = l_r ^ f_out;
    assign last_round_s = (rnd_r == ROUNDS);
    assign last_pass_s  = (pass_r == LAST_PASS);

    des_round_sequencer_swap u_swap (
        .l_in  (l_next_s),
        .r_in  (r_next_s),
        .l_out (swap_l_s),
        .r_out (swap_r_s)
    );

    // State register.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_r <= ST_IDLE;
        end else begin
            state_r <= state_nxt_s;
        end
    end

    // Next-state decode.
    always_comb begin
        state_nxt_s = state_r;
        case (state_r)
            ST_IDLE: begin
                if (in_valid) begin
                    state_nxt_s = ST_ROUND;
                end else begin
                    state_nxt_s = ST_IDLE;
                end
            end
            ST_ROUND: begin
                if (last_round_s && last_pass_s) begin
                    state_nxt_s = ST_DONE;
                end else begin
                    state_nxt_s = ST_ROUND;
                end
            end
            ST_DONE: begin
                if (out_ready) begin
                    state_nxt_s = ST_IDLE;
                end else begin
                    state_nxt_s = ST_DONE;
                end
            end
            default: state_nxt_s = ST_IDLE;
        endcase
    end

    // Feistel datapath, round/pass counters and result registers.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            l_r         <= 32'h0000_0000;
            r_r         <= 32'h0000_0000;
            rnd_r       <= 5'd1;
            pass_r      <= 2'd0;
            dec_r       <= 1'b0;
            left_out_r  <= 32'h0000_0000;
            right_out_r <= 32'h0000_0000;
        end else begin
            case (state_r)
                ST_IDLE: begin
                    if (in_valid) begin
                        l_r    <= left0;
                        r_r    <= right0;
                        rnd_r  <= 5'd1;
                        pass_r <= 2'd0;
                        dec_r  <= decrypt;
                    end
                end
                ST_ROUND: begin
                    if (last_round_s) begin
                        // Swapped halves feed the next pass directly: FP then IP cancel.
                        l_r   <= swap_l_s;
                        r_r   <= swap_r_s;
                        rnd_r <= 5'd1;
                        if (last_pass_s) begin
                            left_out_r  <= swap_l_s;
                            right_out_r <= swap_r_s;
                        end else begin
                            pass_r <= pass_r + 2'd1;
                        end
                    end else begin
                        l_r   <= l_next_s;
                        r_r   <= r_next_s;
                        rnd_r <= rnd_r + 5'd1;
                    end
                end
                default: begin
                    l_r <= l_r;
                end
            endcase
        end
    end

    assign in_ready  = (state_r == ST_IDLE);
    assign out_valid = (state_r == ST_DONE);
    assign f_right   = r_r;
    assign left_out  = left_out_r;
    assign right_out = right_out_r;
    // 17-rnd taken mod 16 is 1-rnd; subkey index 16 appears as 4'h0 on the 4-bit port.
    assign round_num = pass_dec_s ? (4'd1 - rnd_r[3:0]) : rnd_r[3:0];

endmodule

// File: doc/des_round_sequencer.md
DES_ROUND_SEQUENCER -- requirements
Module: des_round_sequencer

Interface
REQ-001 SHALL have one clock and an asynchronous active-low reset; ports listed clock and reset first.
REQ-002 CLK  input  1  rising-edge clock.
REQ-003 RESET_N  input  1  asynchronous active-low reset.
REQ-004 IN_VALID, IN_READY  input, output  1, 1  input block handshake.
REQ-005 DECRYPT  input  1  direction, sampled at input handshake.
REQ-006 LEFT0, RIGHT0  input  32 [32:1] each  post-IP halves, sampled at input handshake.
REQ-007 F_RIGHT  output  32 [32:1]  current right half driven to the external f-function.
REQ-008 F_OUT  input  32 [32:1]  combinational f-function result for the current round.
REQ-009 ROUND_NUM  output  4 [4:1]  subkey index 1..16 for the key schedule, already direction-adjusted.
REQ-010 KEY_SEL  output  2 [2:1]  key bank select: 1 = K1, 2 = K2, 3 = K3.
REQ-011 OUT_VALID, OUT_READY  output, input  1, 1  result handshake.
REQ-012 LEFT_OUT, RIGHT_OUT  output  32 [32:1] each  pre-FP result (R16, L16).

Function
REQ-013 States SHALL be IDLE, ROUND and DONE.
REQ-014 IN_READY SHALL be 1 only in IDLE.
REQ-015 IN_VALID & IN_READY SHALL:
- load L=LEFT0, R=RIGHT0, pass=1, rnd=1;
- latch DECRYPT;
- go to ROUND.
REQ-016 In ROUND, every cycle SHALL update L<=R and R<=L^F_OUT, then increment rnd.
REQ-017 F_RIGHT SHALL always equal R.
REQ-018 ROUND_NUM SHALL be rnd for an encrypt pass and 17-rnd for a decrypt pass.
REQ-019 At the rnd=16 update the SHALL:
- exchange halves (LEFT_OUT=R16, RIGHT_OUT=L16);
- go to DONE when the final pass completes.
REQ-020 Latency: OUT_VALID SHALL assert exactly 16 cycles after the input handshake for a single pass.
REQ-021 In DONE, OUT_VALID=1 and LEFT_OUT/RIGHT_OUT SHALL hold stable until OUT_READY=1, then return to IDLE.
REQ-022 No new input SHALL be accepted in the DONE-to-IDLE cycle.
REQ-023 IN_VALID while busy SHALL be ignored and SHALL NOT affect state.
REQ-024 F_OUT SHALL be ignored outside ROUND.
REQ-025 The round counter SHALL wrap 16 to 1 between passes and never reach 0 or 17.

Reset
REQ-026 RESET_N low SHALL immediately force IDLE, with any operation in progress aborted and its data discarded.
REQ-027 Reset values: IN_READY=1 (after release), OUT_VALID=0, LEFT_OUT=0, RIGHT_OUT=0, F_RIGHT=0, ROUND_NUM=1, KEY_SEL=1.

Configuration
REQ-028 Macro TDES_EN SHALL enable three-pass Triple-DES sequencing.
REQ-029 With TDES_EN, encrypt SHALL run passes E(K1), D(K2), E(K3).
REQ-030 With TDES_EN, decrypt SHALL run passes D(K3), E(K2), D(K1).
REQ-031 With TDES_EN, between passes the swapped halves SHALL feed the next pass directly, since FP and IP cancel. Latency SHALL be 48 cycles.
REQ-032 Without TDES_EN, there SHALL be a single pass with KEY_SEL fixed at 1, and 16-cycle latency.

Structure
REQ-033 Shared package des_pkg SHALL hold:
- state enum;
- ROUNDS=16 constant;
- KEY_SEL encodings;
- pass-direction table.
REQ-034 The final half exchange SHALL instantiate the existing Swap sub-module. There SHALL be no other sub-modules; the f-function and key schedule stay external.

Verification
REQ-035 Encrypt vector: LEFT0=CC00CCFF, RIGHT0=F0AAF0AA, key 133457799BBCDFF1, DECRYPT=0, bench f/key-schedule model -> LEFT_OUT=0A4CD995, RIGHT_OUT=43423234, OUT_VALID at cycle 16.
REQ-036 Decrypt round trip: feed the REQ-035 result halves with DECRYPT=1 -> ROUND_NUM sequence 16..1; output CC00CCFF/F0AAF0AA.
REQ-037 Backpressure: hold OUT_READY=0 for 10 cycles -> outputs stable, IN_READY=0; IN_VALID pulses ignored.
REQ-038 Reset at round 7 -> next cycle OUT_VALID=0, IN_READY=1, outputs 0. A new block then completes correctly.
REQ-039 TDES_EN with K1=K2=K3 -> result equals single-DES encryption of the REQ-035 vector, at cycle 48. KEY_SEL sequence 1,2,3 (encrypt) and 3,2,1 (decrypt).
